// File: rtl/move_ctrl_pkg.sv
// Shared definitions for the player-move controller: FSM states, direction codes
// and the default map geometry / start-of-game values.
package move_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_APPLY   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam int DEF_MAP_W       = 13;
    localparam int DEF_MAP_H       = 13;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_START_X     = 6;
    localparam int DEF_START_Y     = 12;
    localparam int DEF_INIT_HEALTH = 100;

    // Fixed priority: up > down > left > right; lower-priority presses are dropped.
    function automatic dir_t pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        dir_t d;
        if (up) begin
            d = DIR_UP;
        end else if (down) begin
            d = DIR_DOWN;
        end else if (left) begin
            d = DIR_LEFT;
        end else if (right) begin
            d = DIR_RIGHT;
        end else begin
            d = DIR_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/map_addr_gen.sv
// Combinational (floor, x, y) -> linear map RAM address, wrapped at ADDR_W bits.
// Shared with the renderer so both agree on the map layout.
module map_addr_gen
    import move_ctrl_pkg::*;
#(
    parameter int MAP_W  = DEF_MAP_W,
    parameter int MAP_H  = DEF_MAP_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [15:0]       floor_i,
    input  logic [3:0]        x_i,
    input  logic [3:0]        y_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [ADDR_W-1:0] TILES_PER_FLOOR = ADDR_W'(MAP_W * MAP_H);
    localparam logic [ADDR_W-1:0] ROW_STRIDE      = ADDR_W'(MAP_W);

    logic [ADDR_W-1:0] floor_s;
    logic [ADDR_W-1:0] x_s;
    logic [ADDR_W-1:0] y_s;

    assign floor_s = ADDR_W'(floor_i);
    assign x_s     = ADDR_W'(x_i);
    assign y_s     = ADDR_W'(y_i);
    assign addr_o  = floor_s * TILES_PER_FLOOR + y_s * ROW_STRIDE + x_s;

endmodule

// File: rtl/move_ctrl.sv
// Player-move controller: takes one direction request, reads the target tile,
// hands it to the tile resolver and commits the resolver's results.
module move_ctrl
    import move_ctrl_pkg::*;
#(
    parameter int MAP_W       = DEF_MAP_W,
    parameter int MAP_H       = DEF_MAP_H,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int START_X     = DEF_START_X,
    parameter int START_Y     = DEF_START_Y,
    parameter int INIT_HEALTH = DEF_INIT_HEALTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    output logic [3:0]        pos_x,
    output logic [3:0]        pos_y,
    output logic [15:0]       tile_id,
    output logic [15:0]       floor,
    output logic [3:0]        player_x,
    output logic [3:0]        player_y,
    output logic [31:0]       key_num,
    output logic [15:0]       health,
    input  logic [15:0]       r_floor,
    input  logic [3:0]        r_goto_x,
    input  logic [3:0]        r_goto_y,
    input  logic [31:0]       r_key_num,
    input  logic [15:0]       r_health,
    input  logic [15:0]       r_tile_id,
    output logic              busy,
    output logic              move_done
);

    localparam logic [3:0] X_MAX = 4'(MAP_W - 1);
    localparam logic [3:0] Y_MAX = 4'(MAP_H - 1);

    state_t            state_q, state_d;
    logic [3:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [15:0]       tile_id_q, tile_id_d;
    logic [15:0]       floor_q, floor_d;
    logic [3:0]        player_x_q, player_x_d, player_y_q, player_y_d;
    logic [31:0]       key_num_q, key_num_d;
    logic [15:0]       health_q, health_d;
    logic              mem_re_q, mem_re_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    dir_t              dir_s;
    logic [3:0]        tgt_x_s, tgt_y_s;
    logic              tgt_ok_s;
    logic [ADDR_W-1:0] tgt_addr_s;
    logic              apply_s;

    assign dir_s = pick_dir(btn_up, btn_down, btn_left, btn_right);

    // Target tile for the selected direction; off-grid targets are flagged invalid.
    always_comb begin
        tgt_x_s  = player_x_q;
        tgt_y_s  = player_y_q;
        tgt_ok_s = 1'b0;
        case (dir_s)
            DIR_UP: begin
                tgt_y_s  = player_y_q - 4'd1;
                tgt_ok_s = (player_y_q != 4'd0);
            end
            DIR_DOWN: begin
                tgt_y_s  = player_y_q + 4'd1;
                tgt_ok_s = (player_y_q != Y_MAX);
            end
            DIR_LEFT: begin
                tgt_x_s  = player_x_q - 4'd1;
                tgt_ok_s = (player_x_q != 4'd0);
            end
            DIR_RIGHT: begin
                tgt_x_s  = player_x_q + 4'd1;
                tgt_ok_s = (player_x_q != X_MAX);
            end
            default: begin
                tgt_ok_s = 1'b0;
            end
        endcase
    end

    // Floor is stable for the whole move, so this address serves both the read and the write-back.
    map_addr_gen #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H),
        .ADDR_W(ADDR_W)
    ) u_map_addr_gen (
        .floor_i(floor_q),
        .x_i    (tgt_x_s),
        .y_i    (tgt_y_s),
        .addr_o (tgt_addr_s)
    );

    // Next-state logic for the move sequence IDLE -> READ -> CAPTURE -> APPLY.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        tile_id_d  = tile_id_q;
        floor_d    = floor_q;
        player_x_d = player_x_q;
        player_y_d = player_y_q;
        key_num_d  = key_num_q;
        health_d   = health_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        mem_re_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tgt_ok_s) begin
                    state_d    = ST_READ;
                    pos_x_d    = tgt_x_s;
                    pos_y_d    = tgt_y_s;
                    mem_addr_d = tgt_addr_s;
                    mem_re_d   = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                tile_id_d = mem_rdata;
                state_d   = ST_APPLY;
            end
            ST_APPLY: begin
                floor_d    = r_floor;
                player_x_d = r_goto_x;
                player_y_d = r_goto_y;
                key_num_d  = r_key_num;
                health_d   = r_health;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any move in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pos_x_q    <= 4'(START_X);
            pos_y_q    <= 4'(START_Y);
            tile_id_q  <= 16'd0;
            floor_q    <= 16'd0;
            player_x_q <= 4'(START_X);
            player_y_q <= 4'(START_Y);
            key_num_q  <= 32'd0;
            health_q   <= 16'(INIT_HEALTH);
            mem_addr_q <= '0;
            mem_re_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            tile_id_q  <= tile_id_d;
            floor_q    <= floor_d;
            player_x_q <= player_x_d;
            player_y_q <= player_y_d;
            key_num_q  <= key_num_d;
            health_q   <= health_d;
            mem_addr_q <= mem_addr_d;
            mem_re_q   <= mem_re_d;
            busy_q     <= busy_d;
        end
    end

    // Write strobe depends only on the APPLY state flop and the resolver fed from registers.
    assign apply_s   = (state_q == ST_APPLY);
    assign mem_we    = apply_s && (r_tile_id != tile_id_q);
    assign mem_wdata = mem_we ? r_tile_id : 16'd0;
    assign move_done = apply_s;

    assign mem_addr = mem_addr_q;
    assign mem_re   = mem_re_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign tile_id  = tile_id_q;
    assign floor    = floor_q;
    assign player_x = player_x_q;
    assign player_y = player_y_q;
    assign key_num  = key_num_q;
    assign health   = health_q;
    assign busy     = busy_q;

endmodule
